// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - two-requester round-robin APB master
// Optional ACCESS timeout abort enabled by defining APB_TIMEOUT_EN.
module apb_master_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic [1:0]            req,
  input  logic [1:0]            req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr0,
  input  logic [ADDR_WIDTH-1:0] req_addr1,
  input  logic [DATA_WIDTH-1:0] req_wdata0,
  input  logic [DATA_WIDTH-1:0] req_wdata1,
  output logic [1:0]            gnt,
  output logic [1:0]            done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state, state_nxt;
  logic   last;
  logic   win;
  logic   grant;
  logic   timeout_hit;
  logic   xfer_end;

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  // last holds the index of the previous winner; a tie goes to the other one
  always_comb begin
    win = 1'b0;
    unique case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last;
      default: win = 1'b0;
    endcase
  end

  assign grant = (state == IDLE) && (req != 2'b00);

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] tmo_cnt;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tmo_cnt <= '0;
    end else if (state == SETUP) begin
      tmo_cnt <= '0;
    end else if ((state == ACCESS) && !pready) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == ACCESS) && !pready &&
                       (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign xfer_end = (state == ACCESS) && (pready || timeout_hit);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req != 2'b00) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (xfer_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured once at grant and held until the transfer ends
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
      gnt    <= 2'b00;
      last   <= 1'b1;
    end else if (grant) begin
      pwrite <= win ? req_write[1] : req_write[0];
      paddr  <= win ? req_addr1 : req_addr0;
      pwdata <= win ? req_wdata1 : req_wdata0;
      gnt    <= win ? 2'b10 : 2'b01;
      last   <= win;
    end else if (xfer_end) begin
      gnt    <= 2'b00;
    end
  end

  assign psel    = (state != IDLE);
  assign penable = (state == ACCESS);
  assign done    = xfer_end ? gnt : 2'b00;
  assign err     = timeout_hit;
  assign rdata   = ((state == ACCESS) && pready) ? prdata : '0;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - table-driven and sequence checks for apb_master_arbiter
module tb_apb_master_arbiter;

  localparam logic [31:0] A0 = 32'h10;
  localparam logic [31:0] A1 = 32'h20;
  localparam logic [31:0] D0 = 32'hA5;
  localparam logic [31:0] D1 = 32'h5A;

  logic        pclk;
  logic        presetn;
  logic [1:0]  req;
  logic [1:0]  req_write;
  logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
  logic [1:0]  gnt, done;
  logic        err;
  logic [31:0] rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready;

  int checks = 0;
  int errors = 0;

  apb_master_arbiter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .pclk(pclk), .presetn(presetn), .req(req), .req_write(req_write),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  typedef struct {
    logic        rstn;
    logic [1:0]  req;
    logic [1:0]  wr;
    logic        rdy;
    logic [31:0] prd;
    logic        e_psel, e_pen, e_pwr;
    logic [31:0] e_addr, e_wdata;
    logic [1:0]  e_gnt, e_done;
    logic        e_err;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(logic rstn, logic [1:0] rq, logic [1:0] wr, logic rdy,
                             logic [31:0] prd, logic ps, logic pe, logic pw,
                             logic [31:0] ea, logic [31:0] ew, logic [1:0] eg,
                             logic [1:0] ed, logic ee, logic [31:0] er);
    vec_t r;
    r.rstn = rstn; r.req = rq; r.wr = wr; r.rdy = rdy; r.prd = prd;
    r.e_psel = ps; r.e_pen = pe; r.e_pwr = pw; r.e_addr = ea; r.e_wdata = ew;
    r.e_gnt = eg; r.e_done = ed; r.e_err = ee; r.e_rdata = er;
    return r;
  endfunction

  // Row with the bus expected idle (no grant, no completion)
  function automatic vec_t idl(logic rstn, logic [1:0] rq, logic [1:0] wr, logic rdy,
                               logic [31:0] prd);
    return v(rstn, rq, wr, rdy, prd, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge pclk);
    presetn = 1'b0; req = 2'b00; req_write = 2'b00; pready = 1'b0; prdata = '0;
    @(negedge pclk);
    presetn = 1'b1;
  endtask

  initial begin
    presetn = 1'b0; req = 2'b00; req_write = 2'b00; pready = 1'b0; prdata = '0;
    req_addr0 = A0; req_addr1 = A1; req_wdata0 = D0; req_wdata1 = D1;

    // single write from requester 0
    vt.push_back(idl(0, 2'b00, 2'b00, 0, 0));
    vt.push_back(idl(1, 2'b01, 2'b01, 1, 32'h11));
    vt.push_back(v(1, 2'b01, 2'b01, 1, 32'h11, 1, 0, 1, A0, D0, 2'b01, 2'b00, 0, 0));
    vt.push_back(v(1, 2'b01, 2'b01, 1, 32'h11, 1, 1, 1, A0, D0, 2'b01, 2'b01, 0, 32'h11));
    vt.push_back(idl(1, 2'b00, 2'b00, 1, 32'h11));
    // both requesting from reset: grants 0,1,0,1
    vt.push_back(idl(0, 2'b00, 2'b00, 0, 0));
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        vt.push_back(idl(1, 2'b11, 2'b10, 1, 32'h33));
        vt.push_back(v(1, 2'b11, 2'b10, 1, 32'h33, 1, 0, 0, A0, D0, 2'b01, 2'b00, 0, 0));
        vt.push_back(v(1, 2'b11, 2'b10, 1, 32'h33, 1, 1, 0, A0, D0, 2'b01, 2'b01, 0, 32'h33));
      end else begin
        vt.push_back(idl(1, 2'b11, 2'b10, 1, 32'h33));
        vt.push_back(v(1, 2'b11, 2'b10, 1, 32'h33, 1, 0, 1, A1, D1, 2'b10, 2'b00, 0, 0));
        vt.push_back(v(1, 2'b11, 2'b10, 1, 32'h33, 1, 1, 1, A1, D1, 2'b10, 2'b10, 0, 32'h33));
      end
    end
    vt.push_back(idl(1, 2'b00, 2'b00, 1, 32'h33));
    // requester 1 read with three wait states
    vt.push_back(idl(1, 2'b10, 2'b00, 0, 32'hDEADBEEF));
    vt.push_back(v(1, 2'b10, 2'b00, 0, 32'hDEADBEEF, 1, 0, 0, A1, D1, 2'b10, 2'b00, 0, 0));
    for (int k = 0; k < 3; k++)
      vt.push_back(v(1, 2'b10, 2'b00, 0, 32'hDEADBEEF, 1, 1, 0, A1, D1, 2'b10, 2'b00, 0, 0));
    vt.push_back(v(1, 2'b10, 2'b00, 1, 32'hDEADBEEF, 1, 1, 0, A1, D1, 2'b10, 2'b10, 0, 32'hDEADBEEF));
    vt.push_back(idl(1, 2'b00, 2'b00, 0, 32'hDEADBEEF));
    // reset during ACCESS, then round-robin pointer back to requester 0
    vt.push_back(idl(1, 2'b01, 2'b01, 0, 32'h44));
    vt.push_back(v(1, 2'b01, 2'b01, 0, 32'h44, 1, 0, 1, A0, D0, 2'b01, 2'b00, 0, 0));
    vt.push_back(v(1, 2'b01, 2'b01, 0, 32'h44, 1, 1, 1, A0, D0, 2'b01, 2'b00, 0, 0));
    vt.push_back(idl(0, 2'b01, 2'b01, 1, 32'h44));
    vt.push_back(idl(1, 2'b00, 2'b00, 1, 32'h44));
    vt.push_back(idl(1, 2'b11, 2'b00, 1, 32'h44));
    vt.push_back(v(1, 2'b11, 2'b00, 1, 32'h44, 1, 0, 0, A0, D0, 2'b01, 2'b00, 0, 0));
    vt.push_back(v(1, 2'b11, 2'b00, 1, 32'h44, 1, 1, 0, A0, D0, 2'b01, 2'b01, 0, 32'h44));
    vt.push_back(idl(1, 2'b00, 2'b00, 1, 32'h44));

    foreach (vt[i]) begin
      @(negedge pclk);
      presetn = vt[i].rstn; req = vt[i].req; req_write = vt[i].wr;
      pready = vt[i].rdy; prdata = vt[i].prd;
      #1;
      chk($sformatf("row%0d psel", i), 32'(psel), 32'(vt[i].e_psel));
      chk($sformatf("row%0d penable", i), 32'(penable), 32'(vt[i].e_pen));
      chk($sformatf("row%0d gnt", i), 32'(gnt), 32'(vt[i].e_gnt));
      chk($sformatf("row%0d done", i), 32'(done), 32'(vt[i].e_done));
      chk($sformatf("row%0d err", i), 32'(err), 32'(vt[i].e_err));
      chk($sformatf("row%0d rdata", i), rdata, vt[i].e_rdata);
      if (vt[i].e_psel || !vt[i].rstn) begin
        chk($sformatf("row%0d pwrite", i), 32'(pwrite), 32'(vt[i].e_pwr));
        chk($sformatf("row%0d paddr", i), paddr, vt[i].e_addr);
        chk($sformatf("row%0d pwdata", i), pwdata, vt[i].e_wdata);
      end
    end

`ifdef APB_TIMEOUT_EN
    begin
      int n;
      bit seen;
      do_reset();
      @(negedge pclk);
      req = 2'b01; req_write = 2'b00; pready = 1'b0; prdata = 32'hCAFE0000;
      @(negedge pclk);
      @(negedge pclk);
      n = 1;
      seen = 1'b0;
      while (!seen && n <= 40) begin
        #1;
        if (done != 2'b00) begin
          seen = 1'b1;
        end else begin
          n++;
          @(negedge pclk);
        end
      end
      chk("timeout seen", 32'(seen), 32'd1);
      chk("timeout cycle", 32'(n), 32'd16);
      chk("timeout done", 32'(done), 32'(2'b01));
      chk("timeout err", 32'(err), 32'd1);
      chk("timeout rdata", rdata, 32'h0);
      @(negedge pclk);
      req = 2'b10; pready = 1'b1;
      #1;
      chk("after timeout idle", 32'(psel), 32'd0);
      @(negedge pclk);
      @(negedge pclk);
      #1;
      chk("after timeout done", 32'(done), 32'(2'b10));
      chk("after timeout err", 32'(err), 32'd0);
      chk("after timeout rdata", rdata, 32'hCAFE0000);
      @(negedge pclk);
      req = 2'b00;
    end
`else
    begin
      int bad;
      do_reset();
      @(negedge pclk);
      req = 2'b01; req_write = 2'b00; pready = 1'b0; prdata = 32'h77;
      @(negedge pclk);
      @(negedge pclk);
      bad = 0;
      for (int k = 0; k < 100; k++) begin
        #1;
        chk($sformatf("stall%0d", k), {29'd0, penable, done}, {29'd0, 1'b1, 2'b00});
        chk($sformatf("stall%0d err", k), 32'(err), 32'd0);
        @(negedge pclk);
      end
      pready = 1'b1;
      #1;
      chk("stall end done", 32'(done), 32'(2'b01));
      chk("stall end rdata", rdata, 32'h77);
      chk("stall end err", 32'(err), 32'd0);
      @(negedge pclk);
      req = 2'b00; pready = 1'b0;
      #1;
      chk("stall end idle", 32'(psel), 32'd0);
      chk("stall end gnt", 32'(gnt), 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
